// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_arbiter
// Purpose  : Round-robin shares one registered bitwise logic unit among
//            NUM_REQ requesters, one operation in flight at a time.
// Options  : LOGIC_ARB_PERF_EN adds a saturating completed-op counter output.
// Revision : 1.0  initial release
// ============================================================================
module logic_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id
`ifdef LOGIC_ARB_PERF_EN
  ,
  output logic [15:0]              perf_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [1:0]       op_arr [NUM_REQ];
  logic [WIDTH-1:0] a_arr  [NUM_REQ];
  logic [WIDTH-1:0] b_arr  [NUM_REQ];

  logic [IDW-1:0]   grant;
  logic             grant_vld;
  logic [WIDTH-1:0] alu_res;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_arr[i] = req_op[2*i +: 2];
      assign a_arr[i]  = req_a[WIDTH*i +: WIDTH];
      assign b_arr[i]  = req_b[WIDTH*i +: WIDTH];
    end
  endgenerate

  // Scan downward so the requester closest above rr_ptr is the last writer.
  always_comb begin
    logic [IDW:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) begin
        idx = idx - (IDW+1)'(NUM_REQ);
      end
      if (req_valid[idx[IDW-1:0]]) begin
        grant     = idx[IDW-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && grant_vld && rst_n) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = b_q ^ ~a_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          id_d    = grant;
          op_d    = op_arr[grant];
          a_d     = a_arr[grant];
          b_d     = b_arr[grant];
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_res;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          rr_ptr_d    = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef LOGIC_ARB_PERF_EN
  logic [15:0] perf_count_q, perf_count_d;

  always_comb begin
    perf_count_d = perf_count_q;
    if (rsp_valid_q && rsp_ready && (perf_count_q != 16'hFFFF)) begin
      perf_count_d = perf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_count_q <= '0;
    end else begin
      perf_count_q <= perf_count_d;
    end
  end

  assign perf_count = perf_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_op_arbiter
// Purpose  : Self-checking bench for logic_op_arbiter against a transaction
//            model; define LOGIC_ARB_PERF_EN to also cover perf_count.
// Revision : 1.0  initial release
// ============================================================================
module tb_logic_op_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int IDW     = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op = '0;
  logic [WIDTH*NUM_REQ-1:0] req_a = '0;
  logic [WIDTH*NUM_REQ-1:0] req_b = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [WIDTH-1:0]         rsp_data;
  logic [IDW-1:0]           rsp_id;
`ifdef LOGIC_ARB_PERF_EN
  logic [15:0]              perf_count;
`endif

  logic_op_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef LOGIC_ARB_PERF_EN
    ,
    .perf_count(perf_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: one pending result with its age in clock edges.
  int               m_ptr;
  bit               m_pend;
  int               m_age;
  int               m_id;
  logic [WIDTH-1:0] m_data;
  int               m_done;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] op_model(logic [1:0] op, logic [WIDTH-1:0] a,
                                                logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic int exp_grant();
    if (!rst_n || m_pend) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_pend = 0;
    m_age  = 0;
    m_id   = 0;
    m_data = '0;
    m_done = 0;
  endtask

  task automatic compare();
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    bit exp_vld;
    g = exp_grant();
    exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_vld = m_pend && (m_age >= 1);
    check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
    if (exp_vld) begin
      check("rsp_data", 64'(rsp_data), 64'(m_data));
      check("rsp_id", 64'(rsp_id), 64'(m_id));
    end
`ifdef LOGIC_ARB_PERF_EN
    check("perf_count", 64'(perf_count), 64'((m_done > 65535) ? 65535 : m_done));
`endif
  endtask

  task automatic model_edge();
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = exp_grant();
    if (m_pend) begin
      if (m_age >= 1 && rsp_ready) begin
        m_pend = 0;
        m_ptr  = (m_id + 1) % NUM_REQ;
        m_done++;
      end else begin
        m_age++;
      end
    end else if (g >= 0) begin
      m_pend = 1;
      m_age  = 0;
      m_id   = g;
      m_data = op_model(req_op[2*g +: 2], req_a[WIDTH*g +: WIDTH], req_b[WIDTH*g +: WIDTH]);
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(int i, bit v, logic [1:0] op, logic [WIDTH-1:0] a,
                         logic [WIDTH-1:0] b);
    req_valid[i]           = v;
    req_op[2*i +: 2]       = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] lit [4];
  int ids[$];
  int at[$];
  int exp_order[5];

  initial begin
    model_reset();
    lit[0] = 8'h30; lit[1] = 8'hFC; lit[2] = 8'hCC; lit[3] = 8'h33;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    #2;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(0));
    step();
    step();
    rst_n = 1'b1;

    // Single requester, all four ops, fixed operands
    rsp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      set_req(0, 1'b1, 2'(op), 8'hF0, 8'h3C);
      step();
      set_req(0, 1'b0, 2'(op), 8'hF0, 8'h3C);
      step();
      #2;
      check("lit_op_valid", 64'(rsp_valid), 64'(1));
      check("lit_op_data", 64'(rsp_data), 64'(lit[op]));
      check("lit_op_id", 64'(rsp_id), 64'(0));
      step();
    end

    // All requesters valid continuously from a fresh reset
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 1'b1, 2'(i), WIDTH'(8'h11 * (i + 1)), WIDTH'(8'h5A ^ (i * 8'h13)));
    end
    for (int c = 0; c < 15; c++) begin
      step();
      #2;
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        at.push_back(c);
      end
    end
    check("rr_count", 64'(ids.size()), 64'(5));
    for (int i = 0; i < 5 && i < ids.size(); i++) begin
      check("rr_order", 64'(ids[i]), 64'(exp_order[i]));
      if (i > 0) check("rr_interval", 64'(at[i] - at[i-1]), 64'(3));
    end
`ifdef LOGIC_ARB_PERF_EN
    check("perf_five", 64'(perf_count), 64'(5));
`endif
    req_valid = '0;
    step();
    step();
    step();

    // Response backpressure for 10 cycles
    set_req(1, 1'b1, 2'd1, 8'h81, 8'h18);
    step();
    set_req(1, 1'b0, 2'd1, 8'h81, 8'h18);
    rsp_ready = 1'b0;
    step();
    for (int c = 0; c < 10; c++) step();
    rsp_ready = 1'b1;
    step();
    #2;
    check("bp_released", 64'(rsp_valid), 64'(0));

    // Requester 2 alters operands right after its handshake
    set_req(2, 1'b1, 2'd2, 8'hAA, 8'h0F);
    step();
    set_req(2, 1'b1, 2'd2, 8'h00, 8'hFF);
    step();
    #2;
    check("capture_data", 64'(rsp_data), 64'(8'hA5));
    check("capture_id", 64'(rsp_id), 64'(2));
    req_valid = '0;
    step();
    step();

    // Asynchronous reset while an operation is executing
    set_req(3, 1'b1, 2'd0, 8'hFF, 8'hFF);
    step();
    set_req(3, 1'b0, 2'd0, 8'hFF, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("arst_rsp_data", 64'(rsp_data), 64'(0));
    check("arst_rsp_id", 64'(rsp_id), 64'(0));
    check("arst_req_ready", 64'(req_ready), 64'(0));
    model_reset();
    step();
    rst_n = 1'b1;
    req_valid = '1;
    #2;
    check("arst_grant0", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        set_req(i, req_valid[i], 2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

`ifdef LOGIC_ARB_PERF_EN
    // Saturation of the completion counter
    force dut.perf_count_q = 16'hFFFF;
    #1;
    release dut.perf_count_q;
    m_done = 65535;
    set_req(0, 1'b1, 2'd0, 8'h01, 8'h01);
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) step();
    check("perf_saturate", 64'(perf_count), 64'(16'hFFFF));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
